// File: rtl/chroma_skin_segmenter.sv
// rtl/chroma_skin_segmenter.sv - Cb/Cr window skin classifier with aligned RGB, per-frame skin count; optional CHROMA_SKIN_OVERLAY_EN
module chroma_skin_segmenter #(
  parameter int                    bitwidth      = 8,
  parameter int                    count_width   = 20,
  parameter logic [3*bitwidth-1:0] overlay_color = 24'h00FF00
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   pix_valid,
  input  logic                   sof,
  input  logic                   eof,
  input  logic [bitwidth-1:0]    cb_in,
  input  logic [bitwidth-1:0]    cr_in,
  input  logic [bitwidth-1:0]    red_in,
  input  logic [bitwidth-1:0]    green_in,
  input  logic [bitwidth-1:0]    blue_in,
  input  logic [bitwidth-1:0]    cb_min,
  input  logic [bitwidth-1:0]    cb_max,
  input  logic [bitwidth-1:0]    cr_min,
  input  logic [bitwidth-1:0]    cr_max,
  output logic                   mask_out,
  output logic                   mask_valid,
  output logic [bitwidth-1:0]    red_out,
  output logic [bitwidth-1:0]    green_out,
  output logic [bitwidth-1:0]    blue_out,
  output logic [count_width-1:0] skin_count,
  output logic                   count_valid,
  output logic                   frame_active
);

  typedef enum logic [1:0] {IDLE, ACTIVE, REPORT} state_t;

  logic                   s1_valid;
  logic                   s1_sof;
  logic                   s1_eof;
  logic                   s1_cb_ok;
  logic                   s1_cr_ok;
  logic [bitwidth-1:0]    s1_red;
  logic [bitwidth-1:0]    s1_green;
  logic [bitwidth-1:0]    s1_blue;
  logic [3*bitwidth-1:0]  s1_rgb_sel;
  logic                   s2_sof;
  logic                   s2_eof;

  state_t                 state;
  state_t                 state_nxt;
  logic [count_width-1:0] counter;
  logic [count_width-1:0] counter_nxt;
  logic [count_width-1:0] counter_inc;
  logic                   load_report;

`ifdef CHROMA_SKIN_OVERLAY_EN
  // Skin pixels are painted with the overlay colour on their way into stage 2.
  assign s1_rgb_sel = (s1_cb_ok & s1_cr_ok) ? overlay_color : {s1_red, s1_green, s1_blue};
`else
  assign s1_rgb_sel = {s1_red, s1_green, s1_blue};
  wire unused_overlay = ^overlay_color;
`endif

  // Stage 1: window compares; an inverted window (min > max) can never pass both bounds.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
      s1_sof   <= 1'b0;
      s1_eof   <= 1'b0;
      s1_cb_ok <= 1'b0;
      s1_cr_ok <= 1'b0;
      s1_red   <= '0;
      s1_green <= '0;
      s1_blue  <= '0;
    end else begin
      s1_valid <= pix_valid;
      s1_sof   <= pix_valid & sof;
      s1_eof   <= pix_valid & eof;
      if (pix_valid) begin
        s1_cb_ok <= (cb_in >= cb_min) && (cb_in <= cb_max);
        s1_cr_ok <= (cr_in >= cr_min) && (cr_in <= cr_max);
        s1_red   <= red_in;
        s1_green <= green_in;
        s1_blue  <= blue_in;
      end
    end
  end

  // Stage 2: mask and RGB update only on valid pixels so they hold across gaps.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mask_valid <= 1'b0;
      mask_out   <= 1'b0;
      s2_sof     <= 1'b0;
      s2_eof     <= 1'b0;
      red_out    <= '0;
      green_out  <= '0;
      blue_out   <= '0;
    end else begin
      mask_valid <= s1_valid;
      s2_sof     <= s1_sof;
      s2_eof     <= s1_eof;
      if (s1_valid) begin
        mask_out                       <= s1_cb_ok & s1_cr_ok;
        {red_out, green_out, blue_out} <= s1_rgb_sel;
      end
    end
  end

  // Frame state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and counter; the report value is latched on entry to REPORT so it is visible with the pulse.
  always_comb begin
    state_nxt   = state;
    counter_nxt = counter;
    load_report = 1'b0;
    counter_inc = (counter == {count_width{1'b1}}) ? counter : counter + count_width'(mask_out);
    case (state)
      IDLE, REPORT: begin
        if (mask_valid && s2_sof) begin
          counter_nxt = count_width'(mask_out);
          if (s2_eof) begin
            state_nxt   = REPORT;
            load_report = 1'b1;
          end else begin
            state_nxt = ACTIVE;
          end
        end else if (state == REPORT) begin
          state_nxt = IDLE;
        end
      end
      ACTIVE: begin
        if (mask_valid) begin
          counter_nxt = s2_sof ? count_width'(mask_out) : counter_inc;
          if (s2_eof) begin
            state_nxt   = REPORT;
            load_report = 1'b1;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Running counter and the held per-frame result.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      counter    <= '0;
      skin_count <= '0;
    end else begin
      counter <= counter_nxt;
      if (load_report) begin
        skin_count <= counter_nxt;
      end
    end
  end

  assign count_valid  = (state == REPORT);
  assign frame_active = (state == ACTIVE);

endmodule

// File: tb/tb_chroma_skin_segmenter.sv
// tb/tb_chroma_skin_segmenter.sv - randomized self-checking bench for chroma_skin_segmenter
`timescale 1ns/1ps
module tb_chroma_skin_segmenter;
  localparam int BW  = 8;
  localparam int CW  = 20;
  localparam int CWS = 4;
  localparam int N   = 4096;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          pix_valid = 1'b0, sof = 1'b0, eof = 1'b0;
  logic [BW-1:0] cb_in = '0, cr_in = '0, red_in = '0, green_in = '0, blue_in = '0;
  logic [BW-1:0] cb_min = 8'd77, cb_max = 8'd127, cr_min = 8'd133, cr_max = 8'd173;

  logic          mask_out, mask_valid, count_valid, frame_active;
  logic [BW-1:0] red_out, green_out, blue_out;
  logic [CW-1:0] skin_count;
  logic          s_count_valid, s_frame_active;
  logic [CWS-1:0] s_skin_count;
  logic          unused_s_mask_out, unused_s_mask_valid;
  logic [BW-1:0] unused_s_red, unused_s_green, unused_s_blue;

  chroma_skin_segmenter dut (
    .clock(clock), .reset_n(reset_n), .pix_valid(pix_valid), .sof(sof), .eof(eof),
    .cb_in(cb_in), .cr_in(cr_in), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
    .mask_out(mask_out), .mask_valid(mask_valid), .red_out(red_out), .green_out(green_out),
    .blue_out(blue_out), .skin_count(skin_count), .count_valid(count_valid),
    .frame_active(frame_active));

  chroma_skin_segmenter #(.count_width(CWS)) dut_sat (
    .clock(clock), .reset_n(reset_n), .pix_valid(pix_valid), .sof(sof), .eof(eof),
    .cb_in(cb_in), .cr_in(cr_in), .red_in(red_in), .green_in(green_in), .blue_in(blue_in),
    .cb_min(cb_min), .cb_max(cb_max), .cr_min(cr_min), .cr_max(cr_max),
    .mask_out(unused_s_mask_out), .mask_valid(unused_s_mask_valid), .red_out(unused_s_red),
    .green_out(unused_s_green), .blue_out(unused_s_blue), .skin_count(s_skin_count),
    .count_valid(s_count_valid), .frame_active(s_frame_active));

  always #5 clock = ~clock;

  logic [54:0] live_vec;
  assign live_vec = {mask_valid, mask_out, red_out, green_out, blue_out, count_valid, skin_count,
                     frame_active, s_count_valid, s_skin_count, s_frame_active};

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  // expected outputs per cycle, filled in when the input for that cycle is driven
  bit          e_mv[N];
  bit          e_mask[N];
  logic [23:0] e_rgb[N];
  bit          e_cv[N];
  bit          e_act[N];
  int          e_rep[N];

  // frame-level reference state
  bit          m_in_frame;
  int          m_cnt;
  int          m_last_rep;
  bit          m_last_mask;
  logic [23:0] m_last_rgb;

  // observation bookkeeping
  int          vec_miss;
  logic [54:0] first_got, first_want;
  int          first_cyc;
  int          rep_seen;
  logic [CW-1:0]  rep_val;
  logic [CWS-1:0] rep_val_s;
  int          rep_cyc;
  int          eof_cyc;
  int          mv_seen;
  int          mv_cyc;
  logic [15:0] mask_hist;
  logic [23:0] last_rgb_out;

  function automatic int sat(input int v, input int w);
    int lim;
    lim = (1 << w) - 1;
    return (v > lim) ? lim : v;
  endfunction

  function automatic logic [15:0] pick_cc(input bit skin);
    logic [7:0] cb, cr;
    if (skin) begin
      cb = 8'($urandom_range(77, 127));
      cr = 8'($urandom_range(133, 173));
    end else if ($urandom_range(0, 1) == 1) begin
      cb = 8'($urandom_range(0, 76));
      cr = 8'($urandom_range(0, 255));
    end else begin
      cb = 8'($urandom_range(77, 127));
      cr = 8'($urandom_range(174, 255));
    end
    return {cb, cr};
  endfunction

  task automatic model_reset();
    m_in_frame  = 1'b0;
    m_cnt       = 0;
    m_last_rep  = 0;
    m_last_mask = 1'b0;
    m_last_rgb  = '0;
    for (int i = cyc; i < cyc + 4; i++) begin
      e_mv[i] = 0; e_mask[i] = 0; e_rgb[i] = '0; e_cv[i] = 0; e_act[i] = 0; e_rep[i] = 0;
    end
  endtask

  task automatic clear_obs();
    vec_miss = 0; rep_seen = 0; mv_seen = 0; mask_hist = '0;
  endtask

  task automatic tick(input bit v, input bit s, input bit e, input logic [7:0] cb,
                      input logic [7:0] cr, input logic [23:0] rgb);
    bit m;
    bit rep;
    logic [54:0] want;
    if (cyc + 4 >= N) begin
      $display("FAIL cycle_budget cyc=%0d limit=%0d", cyc, N);
      $fatal(1);
    end
    pix_valid = v; sof = s; eof = e; cb_in = cb; cr_in = cr;
    {red_in, green_in, blue_in} = rgb;
    m = (cb >= cb_min) && (cb <= cb_max) && (cr >= cr_min) && (cr <= cr_max);
    if (v) begin
      m_last_mask = m;
      m_last_rgb  = rgb;
`ifdef CHROMA_SKIN_OVERLAY_EN
      if (m) m_last_rgb = 24'h00FF00;
`endif
    end
    e_mv[cyc + 2] = v; e_mask[cyc + 2] = m_last_mask; e_rgb[cyc + 2] = m_last_rgb;
    rep = 1'b0;
    if (v) begin
      if (s) begin
        m_in_frame = 1'b1;
        m_cnt      = int'(m);
      end else if (m_in_frame) begin
        m_cnt = m_cnt + int'(m);
      end
      if (e && m_in_frame) begin
        rep        = 1'b1;
        m_last_rep = m_cnt;
        m_in_frame = 1'b0;
      end
      if (e) eof_cyc = cyc;
    end
    e_cv[cyc + 3] = rep; e_act[cyc + 3] = m_in_frame; e_rep[cyc + 3] = m_last_rep;
    @(negedge clock);
    want = {e_mv[cyc], e_mask[cyc], e_rgb[cyc], e_cv[cyc], CW'(sat(e_rep[cyc], CW)),
            e_act[cyc], e_cv[cyc], CWS'(sat(e_rep[cyc], CWS)), e_act[cyc]};
    if (live_vec !== want) begin
      if (vec_miss == 0) begin
        first_got = live_vec; first_want = want; first_cyc = cyc;
      end
      vec_miss++;
    end
    if (count_valid) begin
      rep_seen++; rep_val = skin_count; rep_val_s = s_skin_count; rep_cyc = cyc;
    end
    if (mask_valid) begin
      mv_seen++; mv_cyc = cyc;
      mask_hist    = {mask_hist[14:0], mask_out};
      last_rgb_out = {red_out, green_out, blue_out};
    end
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic idle(input int k);
    repeat (k) tick(1'b0, 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 24'($urandom));
  endtask

  task automatic send_frame(input int n, input int nskin, input int gap_pct,
                            input bit with_sof, input bit with_eof);
    bit flags[64];
    bit t;
    int j;
    logic [15:0] cc;
    for (int i = 0; i < n; i++) flags[i] = (i < nskin);
    for (int i = 0; i < n; i++) begin
      j = $urandom_range(0, n - 1);
      t = flags[i]; flags[i] = flags[j]; flags[j] = t;
    end
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 99) < gap_pct) idle(1);
      cc = pick_cc(flags[i]);
      tick(1'b1, with_sof && (i == 0), with_eof && (i == n - 1), cc[15:8], cc[7:0], 24'($urandom));
    end
  endtask

  task automatic test_reset();
    clear_obs();
    @(posedge clock);
    #1;
    total++;
    if (live_vec !== '0) begin
      bad++; $display("FAIL reset_outputs got=%h want=0", live_vec);
    end
    cyc = 0;
    model_reset();
    idle(2);
    reset_n = 1'b1;
    idle(3);
    total++;
    if (vec_miss !== 0) begin
      bad++; $display("FAIL reset_pipeline misses=%0d cyc=%0d got=%h want=%h", vec_miss, first_cyc, first_got, first_want);
    end
  endtask

  task automatic test_boundaries();
    logic [7:0] cbs [9];
    logic [7:0] crs [9];
    int c0;
    cbs = '{8'd100, 8'd76, 8'd77, 8'd127, 8'd128, 8'd100, 8'd100, 8'd100, 8'd100};
    crs = '{8'd150, 8'd150, 8'd150, 8'd150, 8'd150, 8'd132, 8'd133, 8'd173, 8'd174};
    clear_obs();
    for (int i = 0; i < 9; i++) tick(1'b1, 1'b0, 1'b0, cbs[i], crs[i], 24'($urandom));
    idle(3);
    total++;
    if (mask_hist[8:0] !== 9'b101100110) begin
      bad++; $display("FAIL boundary_masks got=%b want=101100110", mask_hist[8:0]);
    end
    clear_obs();
    c0 = cyc;
    tick(1'b1, 1'b0, 1'b0, 8'd100, 8'd150, 24'h123456);
    idle(4);
    total++;
    if (mv_seen !== 1 || mv_cyc - c0 !== 2 || mask_hist[0] !== 1'b1) begin
      bad++; $display("FAIL latency seen=%0d lat=%0d mask=%b want seen=1 lat=2 mask=1", mv_seen, mv_cyc - c0, mask_hist[0]);
    end
    total++;
    if (vec_miss !== 0) begin
      bad++; $display("FAIL boundary_pipeline misses=%0d cyc=%0d got=%h want=%h", vec_miss, first_cyc, first_got, first_want);
    end
  endtask

  task automatic test_frame_count();
    clear_obs();
    send_frame(16, 5, 0, 1'b1, 1'b1);
    idle(5);
    total++;
    if (rep_seen !== 1 || rep_val !== 20'd5) begin
      bad++; $display("FAIL frame_count reports=%0d count=%0d want reports=1 count=5", rep_seen, rep_val);
    end
    total++;
    if (rep_cyc - eof_cyc !== 3) begin
      bad++; $display("FAIL report_delay got=%0d want=3", rep_cyc - eof_cyc);
    end
    total++;
    if (frame_active !== 1'b0) begin
      bad++; $display("FAIL frame_active_after got=%b want=0", frame_active);
    end
    clear_obs();
    send_frame(16, 7, 30, 1'b1, 1'b1);
    idle(5);
    total++;
    if (rep_seen !== 1 || rep_val !== 20'd7) begin
      bad++; $display("FAIL gapped_frame reports=%0d count=%0d want reports=1 count=7", rep_seen, rep_val);
    end
    total++;
    if (vec_miss !== 0) begin
      bad++; $display("FAIL frame_pipeline misses=%0d cyc=%0d got=%h want=%h", vec_miss, first_cyc, first_got, first_want);
    end
  endtask

  task automatic test_sof_abort();
    clear_obs();
    send_frame(6, 3, 0, 1'b1, 1'b0);
    send_frame(10, 2, 0, 1'b1, 1'b1);
    idle(5);
    total++;
    if (rep_seen !== 1 || rep_val !== 20'd2) begin
      bad++; $display("FAIL sof_abort reports=%0d count=%0d want reports=1 count=2", rep_seen, rep_val);
    end
    total++;
    if (vec_miss !== 0) begin
      bad++; $display("FAIL abort_pipeline misses=%0d cyc=%0d got=%h want=%h", vec_miss, first_cyc, first_got, first_want);
    end
  endtask

  task automatic test_saturation();
    clear_obs();
    send_frame(20, 20, 0, 1'b1, 1'b1);
    idle(5);
    total++;
    if (rep_val !== 20'd20 || rep_val_s !== 4'd15) begin
      bad++; $display("FAIL saturation wide=%0d narrow=%0d want wide=20 narrow=15", rep_val, rep_val_s);
    end
    total++;
    if (vec_miss !== 0) begin
      bad++; $display("FAIL sat_pipeline misses=%0d cyc=%0d got=%h want=%h", vec_miss, first_cyc, first_got, first_want);
    end
  endtask

  task automatic test_mid_frame_reset();
    clear_obs();
    send_frame(8, 4, 0, 1'b1, 1'b0);
    reset_n = 1'b0;
    #1;
    total++;
    if (live_vec !== '0) begin
      bad++; $display("FAIL async_reset got=%h want=0", live_vec);
    end
    model_reset();
    idle(2);
    reset_n = 1'b1;
    clear_obs();
    send_frame(12, 6, 20, 1'b1, 1'b1);
    idle(5);
    total++;
    if (rep_seen !== 1 || rep_val !== 20'd6) begin
      bad++; $display("FAIL post_reset_frame reports=%0d count=%0d want reports=1 count=6", rep_seen, rep_val);
    end
    total++;
    if (vec_miss !== 0) begin
      bad++; $display("FAIL reset_frame_pipeline misses=%0d cyc=%0d got=%h want=%h", vec_miss, first_cyc, first_got, first_want);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] cc;
    clear_obs();
    send_frame(5, 2, 0, 1'b1, 1'b1);
    send_frame(4, 3, 0, 1'b1, 1'b1);
    idle(5);
    total++;
    if (rep_seen !== 2 || rep_val !== 20'd3) begin
      bad++; $display("FAIL back_to_back reports=%0d last=%0d want reports=2 last=3", rep_seen, rep_val);
    end
    clear_obs();
    tick(1'b1, 1'b1, 1'b1, 8'd100, 8'd150, 24'($urandom));
    idle(5);
    tick(1'b1, 1'b0, 1'b1, 8'd100, 8'd150, 24'($urandom));
    idle(5);
    total++;
    if (rep_seen !== 1 || rep_val !== 20'd1) begin
      bad++; $display("FAIL single_pixel_and_idle_eof reports=%0d count=%0d want reports=1 count=1", rep_seen, rep_val);
    end
    for (int it = 0; it < 40; it++) begin
      case ($urandom_range(0, 5))
        0: send_frame($urandom_range(1, 12), $urandom_range(0, 1) == 1 ? 1 : 0, 25, 1'b1, 1'b1);
        1: begin
          cc = pick_cc(1'($urandom));
          tick(1'b1, 1'b1, 1'b1, cc[15:8], cc[7:0], 24'($urandom));
        end
        2: begin
          cc = pick_cc(1'($urandom));
          tick(1'b1, 1'b0, 1'b1, cc[15:8], cc[7:0], 24'($urandom));
        end
        3: idle($urandom_range(0, 3));
        4: begin
          cb_min = 8'($urandom); cb_max = 8'($urandom);
          cr_min = 8'($urandom); cr_max = 8'($urandom);
          repeat (6) tick(1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 24'($urandom));
        end
        default: send_frame($urandom_range(2, 10), $urandom_range(0, 2), 25, 1'b1, 1'b0);
      endcase
    end
    cb_min = 8'd77; cb_max = 8'd127; cr_min = 8'd133; cr_max = 8'd173;
    send_frame(9, 4, 25, 1'b1, 1'b1);
    idle(5);
    total++;
    if (vec_miss !== 0) begin
      bad++; $display("FAIL random_pipeline misses=%0d cyc=%0d got=%h want=%h", vec_miss, first_cyc, first_got, first_want);
    end
  endtask

  task automatic test_overlay();
    logic [23:0] skin_want;
`ifdef CHROMA_SKIN_OVERLAY_EN
    skin_want = 24'h00FF00;
`else
    skin_want = {8'd200, 8'd150, 8'd120};
`endif
    clear_obs();
    tick(1'b1, 1'b0, 1'b0, 8'd100, 8'd150, {8'd200, 8'd150, 8'd120});
    idle(3);
    total++;
    if (last_rgb_out !== skin_want) begin
      bad++; $display("FAIL overlay_skin got=%h want=%h", last_rgb_out, skin_want);
    end
    tick(1'b1, 1'b0, 1'b0, 8'd50, 8'd150, {8'd200, 8'd150, 8'd120});
    idle(3);
    total++;
    if (last_rgb_out !== {8'd200, 8'd150, 8'd120}) begin
      bad++; $display("FAIL overlay_nonskin got=%h want=c89678", last_rgb_out);
    end
    total++;
    if (vec_miss !== 0) begin
      bad++; $display("FAIL overlay_pipeline misses=%0d cyc=%0d got=%h want=%h", vec_miss, first_cyc, first_got, first_want);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      e_mv[i] = 0; e_mask[i] = 0; e_rgb[i] = '0; e_cv[i] = 0; e_act[i] = 0; e_rep[i] = 0;
    end
    test_reset();
    test_boundaries();
    test_frame_count();
    test_sof_abort();
    test_saturation();
    test_mid_frame_reset();
    test_back_to_back();
    test_overlay();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached at cyc=%0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/chroma_skin_segmenter.md
Name: chroma_skin_segmenter

Overview:
- Consumes the Cb/Cr chroma and pass-through RGB produced by the colour-space conversion stage.
- Classifies each pixel as skin or non-skin using programmable inclusive Cb/Cr window thresholds.
- Outputs a 1-bit mask with RGB aligned to it, plus a per-frame skin-pixel count with a one-cycle report pulse.
- Sits directly downstream of the RGB-to-YCrCb stage and feeds the mask/blob stages.

Parameters:
- bitwidth, 8, width of each colour/chroma component.
- count_width, 20, width of the per-frame skin-pixel counter.
- overlay_color, 24'h00FF00, {R,G,B} substituted on skin pixels when the optional feature is built in.

Ports:
- clock  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- pix_valid  input  1  cb_in/cr_in/rgb/sof/eof are valid this cycle.
- sof  input  1  first pixel of frame; qualified by pix_valid.
- eof  input  1  last pixel of frame; qualified by pix_valid.
- cb_in  input  bitwidth  Cb from upstream, unsigned.
- cr_in  input  bitwidth  Cr from upstream, unsigned.
- red_in, green_in, blue_in  input  bitwidth each  RGB aligned with cb_in/cr_in.
- cb_min, cb_max, cr_min, cr_max  input  bitwidth each  inclusive thresholds, quasi-static.
- mask_out  output  1  1 = skin pixel.
- mask_valid  output  1  mask_out/rgb outputs valid.
- red_out, green_out, blue_out  output  bitwidth each  RGB aligned with mask_out.
- skin_count  output  count_width  skin pixels in last completed frame; held until the next report.
- count_valid  output  1  one-cycle pulse when skin_count updates.
- frame_active  output  1  high while the FSM is in ACTIVE.

Behaviour:
- Reset: all outputs 0, FSM in IDLE, internal counter 0. Reset is asynchronous and takes effect mid-frame, discarding any partial frame.
- Stage 1 (registered):
  - cb_ok = cb_min <= cb_in <= cb_max.
  - cr_ok = cr_min <= cr_in <= cr_max.
  - Comparisons are unsigned.
  - If min > max for either channel, that channel is never ok.
  - Stage 1 registers RGB, valid, sof and eof.
- Stage 2 (registered): mask_out = cb_ok & cr_ok; RGB, mask_valid and the frame flags are registered.
- Latency: exactly 2 cycles from pix_valid to mask_valid.
  - No backpressure; gaps in pix_valid propagate unchanged.
  - mask_out and RGB outputs hold their last values while mask_valid = 0.
- Counter: updates on stage-2 valid pixels only.
  - Saturates at 2^count_width-1 and does not wrap.
- FSM states: IDLE, ACTIVE, REPORT.
  - IDLE: on stage-2 valid with sof, counter loads mask_out (0/1) and FSM goes to ACTIVE. Pixels without sof are masked but not counted.
  - ACTIVE: each valid pixel adds mask_out.
    - Valid with sof: counter reloads with mask_out and FSM stays in ACTIVE; the aborted frame is not reported.
    - Valid with eof: FSM goes to REPORT. The final pixel's contribution is included in the count.
  - REPORT (one cycle): skin_count <= counter, count_valid = 1, FSM goes to IDLE.
    - count_valid is high the cycle after the final pixel's mask_valid, i.e. 3 cycles after the eof input.
    - If a valid sof pixel is on stage 2 during REPORT, it is handled as in IDLE (counter loads, FSM goes to ACTIVE) with no lost pixel.
  - sof and eof on the same pixel: one-pixel frame; the FSM goes directly from IDLE to REPORT.
  - eof while in IDLE: ignored.
- frame_active = 1 only in ACTIVE.

Optional Feature:
- Macro: CHROMA_SKIN_OVERLAY_EN.
- Defined: on valid pixels with mask_out = 1, {red_out, green_out, blue_out} = overlay_color; otherwise the input RGB. Latency is unchanged.
- Undefined: RGB outputs are always the delayed input RGB; overlay_color is unused.

Test Plan:
- Thresholds Cb 77..127, Cr 133..173:
  - Pixel cb=100, cr=150 -> mask_out=1 two cycles later.
  - cb=76 -> 0; cb=77 -> 1; cb=127 -> 1; cb=128 -> 0 (inclusive boundaries).
- 4x4 frame (sof on pixel 0, eof on pixel 15) with 5 skin pixels -> count_valid pulse 3 cycles after eof, skin_count=5, frame_active low afterwards.
- sof at pixel 6 of a frame with 3 skin pixels so far, new frame has 2 skin pixels -> single report with skin_count=2.
- count_width=4, 20 skin pixels in a frame -> skin_count=15 (saturated).
- Assert reset_n low mid-frame -> all outputs 0 immediately; the next frame reports correctly.
- With CHROMA_SKIN_OVERLAY_EN: skin pixel with RGB (200,150,120) -> output (0,255,0); non-skin pixel -> RGB unchanged. Without the macro -> RGB unchanged in both cases.
